// File: rtl/clk_tick_divider.sv
// Programmable single-cycle tick generator with 50% square wave and wrapping tick counter.
// Divisor reloads take effect only at period boundaries, so every period is full length.
module clk_tick_divider #(
    parameter int unsigned DIV_W       = 32,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned DEFAULT_DIV = 100000
) (
    input  logic             clk_100M,
    input  logic             rst,
    input  logic             enable,
    input  logic             div_load,
    input  logic [DIV_W-1:0] div_value,
    output logic             tick,
    output logic             clk_sq,
    output logic [CNT_W-1:0] tick_count,
    output logic [DIV_W-1:0] div_active,
    output logic             load_ack,
    output logic             load_err
);

    localparam logic [DIV_W-1:0] DIV_RESET = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] DIV_MIN   = DIV_W'(2);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] pending_q, pending_d;
    logic             pending_valid_q, pending_valid_d;
    logic             tick_q, tick_d;
    logic             clk_sq_q, clk_sq_d;
    logic [CNT_W-1:0] tick_count_q, tick_count_d;
    logic [DIV_W-1:0] div_active_q, div_active_d;
    logic             load_ack_q, load_ack_d;
    logic             load_err_q, load_err_d;

    logic terminal;
    logic period_end;
    logic apply;
    logic load_ok;
    logic load_bad;

    assign terminal   = (cnt_q == div_active_q - DIV_W'(1));
    assign period_end = enable && terminal;
    // A pending divisor lands either on a period boundary or immediately while idle.
    assign apply      = pending_valid_q && (!enable || terminal);
    assign load_ok    = div_load && (div_value >= DIV_MIN);
    assign load_bad   = div_load && (div_value < DIV_MIN);

    always_comb begin
        cnt_d           = cnt_q;
        pending_d       = pending_q;
        pending_valid_d = pending_valid_q;
        clk_sq_d        = clk_sq_q;
        tick_count_d    = tick_count_q;
        div_active_d    = div_active_q;
        tick_d          = period_end;
        load_ack_d      = apply;
        load_err_d      = load_bad;

        if (period_end) begin
            cnt_d        = '0;
            clk_sq_d     = ~clk_sq_q;
            tick_count_d = tick_count_q + CNT_W'(1);
        end else if (enable) begin
            cnt_d = cnt_q + DIV_W'(1);
        end

        if (apply) begin
            cnt_d           = '0;
            div_active_d    = pending_q;
            pending_valid_d = 1'b0;
        end

        // A fresh load on the apply edge refills pending for the following boundary.
        if (load_ok) begin
            pending_d       = div_value;
            pending_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk_100M) begin
        if (rst) begin
            cnt_q           <= '0;
            pending_q       <= DIV_RESET;
            pending_valid_q <= 1'b0;
            tick_q          <= 1'b0;
            clk_sq_q        <= 1'b0;
            tick_count_q    <= '0;
            div_active_q    <= DIV_RESET;
            load_ack_q      <= 1'b0;
            load_err_q      <= 1'b0;
        end else begin
            cnt_q           <= cnt_d;
            pending_q       <= pending_d;
            pending_valid_q <= pending_valid_d;
            tick_q          <= tick_d;
            clk_sq_q        <= clk_sq_d;
            tick_count_q    <= tick_count_d;
            div_active_q    <= div_active_d;
            load_ack_q      <= load_ack_d;
            load_err_q      <= load_err_d;
        end
    end

    assign tick       = tick_q;
    assign clk_sq     = clk_sq_q;
    assign tick_count = tick_count_q;
    assign div_active = div_active_q;
    assign load_ack   = load_ack_q;
    assign load_err   = load_err_q;

endmodule

// File: tb/tb_clk_tick_divider.sv
// Bench for clk_tick_divider: directed stimulus pushes hand-computed events
// (edge number plus output snapshot) that a monitor pops whenever tick/load_ack/load_err fires.
module tb_clk_tick_divider;

    logic        clk_100M = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        div_load = 1'b0;
    logic [31:0] div_value = '0;
    logic        tick;
    logic        clk_sq;
    logic [3:0]  tick_count;
    logic [31:0] div_active;
    logic        load_ack;
    logic        load_err;

    int errors = 0;
    int checks = 0;
    int edge_n = 0;
    int r0;
    int r1;

    // {edge[15:0], tick, load_ack, load_err, clk_sq, tick_count[15:0], div_active[31:0]}
    logic [67:0] exp_q[$];

    clk_tick_divider #(
        .DIV_W(32),
        .CNT_W(4),
        .DEFAULT_DIV(4)
    ) dut (
        .clk_100M  (clk_100M),
        .rst       (rst),
        .enable    (enable),
        .div_load  (div_load),
        .div_value (div_value),
        .tick      (tick),
        .clk_sq    (clk_sq),
        .tick_count(tick_count),
        .div_active(div_active),
        .load_ack  (load_ack),
        .load_err  (load_err)
    );

    // clock / reset
    always #5 clk_100M = ~clk_100M;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, edge=%0d", edge_n);
        $fatal(1, "watchdog");
    end

    function automatic logic [67:0] mk_ev(input int e, input logic t, input logic a,
                                          input logic er, input logic sq, input int tc,
                                          input int dv);
        return {16'(e), t, a, er, sq, 16'(tc), 32'(dv)};
    endfunction

    // monitor / scoreboard
    always @(posedge clk_100M) begin
        logic [67:0] obs;
        logic [67:0] exp_v;
        #1;
        edge_n = edge_n + 1;
        if (tick === 1'b1 || load_ack === 1'b1 || load_err === 1'b1) begin
            obs = mk_ev(edge_n, tick, load_ack, load_err, clk_sq, int'(tick_count),
                        int'(div_active));
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL event: unexpected output event %h at edge %0d, required none",
                         obs, edge_n);
            end else begin
                exp_v = exp_q.pop_front();
                if (obs !== exp_v) begin
                    errors++;
                    $display("FAIL event: got %h required %h (edge %0d)", obs, exp_v, edge_n);
                end
            end
        end
    end

    // driver tasks
    task automatic goto(input int e);
        while (edge_n < e) @(negedge clk_100M);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d required %0d (edge %0d)", name, act, exp_v, edge_n);
        end
    endtask

    task automatic chk_reset_state();
        chk("rst_tick", 32'(tick), 0);
        chk("rst_clk_sq", 32'(clk_sq), 0);
        chk("rst_tick_count", 32'(tick_count), 0);
        chk("rst_div_active", div_active, 4);
        chk("rst_load_ack", 32'(load_ack), 0);
        chk("rst_load_err", 32'(load_err), 0);
    endtask

    task automatic load_at(input int e, input int v);
        goto(e - 1);
        div_load  = 1'b1;
        div_value = 32'(v);
        goto(e);
        div_load  = 1'b0;
        div_value = '0;
    endtask

    initial begin
        // reset edges 1..3, then edge r0+k is post-reset edge k
        goto(3);
        chk_reset_state();
        rst    = 1'b0;
        enable = 1'b1;
        r0     = 3;

        // default divisor 4: ticks at edges 4, 8, 12
        for (int k = 1; k <= 3; k++) exp_q.push_back(mk_ev(r0 + 4 * k, 1, 0, 0, k % 2, k, 4));

        // load 6 while cnt=1: applied with the tick at r0+16, then every 6 edges
        goto(r0 + 13);
        exp_q.push_back(mk_ev(r0 + 16, 1, 1, 0, 0, 4, 6));
        exp_q.push_back(mk_ev(r0 + 22, 1, 0, 0, 1, 5, 6));
        exp_q.push_back(mk_ev(r0 + 28, 1, 0, 0, 0, 6, 6));
        load_at(r0 + 14, 6);

        // illegal divisors 1 and 0: load_err only, spacing unchanged
        goto(r0 + 29);
        exp_q.push_back(mk_ev(r0 + 30, 0, 0, 1, 0, 6, 6));
        exp_q.push_back(mk_ev(r0 + 33, 0, 0, 1, 0, 6, 6));
        exp_q.push_back(mk_ev(r0 + 34, 1, 0, 0, 1, 7, 6));
        exp_q.push_back(mk_ev(r0 + 40, 1, 0, 0, 0, 8, 6));
        load_at(r0 + 30, 1);
        load_at(r0 + 33, 0);
        goto(r0 + 40);
        chk("div_after_err", div_active, 6);

        // back to 4, disable at cnt=2, load 5 while idle, re-enable
        exp_q.push_back(mk_ev(r0 + 46, 1, 1, 0, 1, 9, 4));
        exp_q.push_back(mk_ev(r0 + 51, 0, 1, 0, 1, 9, 5));
        exp_q.push_back(mk_ev(r0 + 63, 1, 0, 0, 0, 10, 5));
        exp_q.push_back(mk_ev(r0 + 68, 1, 0, 0, 1, 11, 5));
        load_at(r0 + 41, 4);
        goto(r0 + 48);
        enable = 1'b0;
        load_at(r0 + 50, 5);
        goto(r0 + 58);
        chk("hold_tick_count", 32'(tick_count), 9);
        chk("hold_clk_sq", 32'(clk_sq), 1);
        chk("hold_div_active", div_active, 5);
        enable = 1'b1;

        // minimum divisor 2 through a tick_count wrap (15 -> 0)
        goto(r0 + 68);
        exp_q.push_back(mk_ev(r0 + 73, 1, 1, 0, 0, 12, 2));
        for (int k = 1; k <= 16; k++)
            exp_q.push_back(mk_ev(r0 + 73 + 2 * k, 1, 0, 0, k % 2, (12 + k) % 16, 2));
        load_at(r0 + 69, 2);
        goto(r0 + 81);
        chk("wrap_tick_count", 32'(tick_count), 0);

        // divisor 8, then reset at cnt=3 with load 9 pending
        goto(r0 + 105);
        exp_q.push_back(mk_ev(r0 + 107, 1, 1, 0, 1, 13, 8));
        load_at(r0 + 106, 8);
        load_at(r0 + 110, 9);
        rst = 1'b1;
        goto(r0 + 111);
        chk_reset_state();
        rst = 1'b0;
        r1  = r0 + 111;
        exp_q.push_back(mk_ev(r1 + 4, 1, 0, 0, 1, 1, 4));
        exp_q.push_back(mk_ev(r1 + 8, 1, 0, 0, 0, 2, 4));
        goto(r1 + 10);
        chk("queue_empty", 32'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
